cache_fill_ctrl: RTL and testbench
==================================

Name: cache_fill_ctrl

Overview:
- Sequences block refills for the I-cache and D-cache over the single shared main-memory port.
- Arbitrates between simultaneous misses; D-cache has fixed priority.
- Streams returned words into the owning cache, then writes its tag.
- Drives the stall inputs of the pipeline registers (IF stage and MEM/WB) while a miss is outstanding.

Parameters:
ADDR_WIDTH, 16, byte address width
DATA_WIDTH, 16, word width; one word = 2 bytes
WORDS_PER_BLOCK, 8, words per cache block; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset
- icache_miss  in  1  I-cache miss; held high until the tag is written
- icache_miss_addr  in  ADDR_WIDTH  missing I-fetch byte address
- dcache_miss  in  1  D-cache miss; held high until the tag is written
- dcache_miss_addr  in  ADDR_WIDTH  missing data byte address
- mem_en  out  1  main-memory read request, one word per cycle
- mem_addr  out  ADDR_WIDTH  main-memory word byte address
- mem_data_in  in  DATA_WIDTH  returned read data
- mem_data_valid  in  1  mem_data_in valid this cycle
- fill_data  out  DATA_WIDTH  mem_data_in pass-through to the cache data array
- fill_word_idx  out  log2(WORDS_PER_BLOCK)  word slot being written
- fill_wen_i  out  1  I-cache data-array write enable
- fill_wen_d  out  1  D-cache data-array write enable
- fill_tag_wen_i  out  1  I-cache tag/valid write, single-cycle pulse
- fill_tag_wen_d  out  1  D-cache tag/valid write, single-cycle pulse
- fill_base_addr  out  ADDR_WIDTH  block-aligned address of the current fill
- stall_if  out  1  stall for the IF-stage registers
- stall_mem  out  1  stall for the EX/MEM and MEM/WB registers

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset: state=IDLE; owner, counters, base, mem_addr = 0.
  - All registered outputs 0; all write enables 0.
  - A reset during a fill aborts it with no tag write. The partial block stays invalid.
- State register: IDLE, ISSUE, WAIT, DONE. Owner register: I or D.
- IDLE:
  - If dcache_miss: owner=D, base = dcache_miss_addr with the low log2(2*WORDS_PER_BLOCK) bits cleared; go to ISSUE.
  - Else if icache_miss: same, using owner=I and icache_miss_addr.
  - Both misses together: D is served first; I is served after D's DONE.
  - mem_data_valid is ignored in IDLE.
- ISSUE:
  - mem_en=1 and mem_addr = base + 2*issue_cnt, for issue_cnt = 0..WORDS_PER_BLOCK-1.
  - Exactly WORDS_PER_BLOCK consecutive cycles, then go to WAIT.
  - mem_en is 0 in every other state.
- Receive path, ISSUE or WAIT, recv_cnt < WORDS_PER_BLOCK:
  - Each mem_data_valid writes mem_data_in to slot recv_cnt; recv_cnt increments.
  - fill_wen_i/fill_wen_d = mem_data_valid & (owner==I / owner==D).
  - fill_word_idx = recv_cnt.
  - Valid beyond WORDS_PER_BLOCK words is ignored.
- WAIT: go to DONE in the cycle after the last word is received.
  - The last word may already arrive in ISSUE if latency ≤ 0; then ISSUE goes straight to DONE.
- DONE: exactly one cycle.
  - fill_tag_wen_<owner>=1 with fill_base_addr valid.
  - Next state IDLE.
  - The cache drops its miss in the cycle after DONE, so IDLE never re-triggers on a stale miss.
- Stalls, combinational:
  - stall_if = icache_miss | (state!=IDLE & owner==I)
  - stall_mem = dcache_miss | (state!=IDLE & owner==D)
  - Both may be high together.
- Miss deasserted mid-fill (illegal): the fill still completes, tag write included.
- Address arithmetic is modulo 2^ADDR_WIDTH; a block at the top of the space wraps.
- Timing, miss first seen in IDLE at cycle T, WORDS_PER_BLOCK=8, memory latency L:
  - ISSUE T+1..T+8.
  - Data T+1+L..T+8+L.
  - DONE T+9+L.
  - IDLE T+10+L.

Test Plan:
- Reset then dcache_miss=1, addr 0x1236, memory latency 4:
  - mem_addr sequence 0x1230, 0x1232 … 0x123E on 8 consecutive cycles.
  - fill_wen_d with idx 0..7.
  - fill_tag_wen_d 13 cycles after the miss; fill_base_addr=0x1230.
  - stall_mem high throughout; stall_if 0.
- icache_miss and dcache_miss asserted in the same cycle (I 0x0040, D 0x8008):
  - D fill of 0x8000 completes first, while stall_if stays high.
  - I fill of 0x0040 starts in the first IDLE cycle after D's DONE.
  - fill_wen_i never asserts during the D fill.
- Memory inserting valid bubbles (valid pattern 1,0,1,1,0,…):
  - fill_word_idx advances only on valid.
  - DONE only after the 8th valid.
- 10 valid pulses, 2 of them after the 8th:
  - Extra words produce no fill_wen.
  - Exactly one tag-write pulse.
- rst asserted mid-fill, after 3 words received:
  - Next cycle: state IDLE, all outputs 0, no tag write.
  - The held miss restarts the fill from word 0.
- icache_miss at addr 0xFFFE: base 0xFFF0; mem_addr runs 0xFFF0..0xFFFE.

Source files
------------

// File: rtl/cache_fill_ctrl_if.sv
// cache_fill_ctrl_if
// Bundles every signal between the block-refill controller, the two caches
// and the main-memory read port. clk/rst are not part of the bundle.
//
// Handshake rules (one place, applies to the whole bundle):
//   - icache_miss / dcache_miss are level requests. The cache raises the
//     miss with a stable address and holds it until it has seen the
//     matching fill_tag_wen_* pulse, then drops it in the following cycle.
//     There is no ready signal; acceptance is implied by the stall outputs.
//   - mem_en/mem_addr issue one word read per cycle with no back-pressure.
//     The memory answers in request order, one word per mem_data_valid
//     cycle, with arbitrary latency and arbitrary bubbles.
//   - fill_wen_* mark the cycles in which fill_data is written to slot
//     fill_word_idx. fill_tag_wen_* are single-cycle pulses qualified by
//     fill_base_addr.
//
// Modports:
//   master : the fill controller
//   slave  : the environment (caches + main memory)
interface cache_fill_ctrl_if #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8
);
    logic                               icache_miss;
    logic [ADDR_WIDTH-1:0]              icache_miss_addr;
    logic                               dcache_miss;
    logic [ADDR_WIDTH-1:0]              dcache_miss_addr;
    logic                               mem_en;
    logic [ADDR_WIDTH-1:0]              mem_addr;
    logic [DATA_WIDTH-1:0]              mem_data_in;
    logic                               mem_data_valid;
    logic [DATA_WIDTH-1:0]              fill_data;
    logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_idx;
    logic                               fill_wen_i;
    logic                               fill_wen_d;
    logic                               fill_tag_wen_i;
    logic                               fill_tag_wen_d;
    logic [ADDR_WIDTH-1:0]              fill_base_addr;
    logic                               stall_if;
    logic                               stall_mem;

    modport master (
        input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
        input  mem_data_in, mem_data_valid,
        output mem_en, mem_addr,
        output fill_data, fill_word_idx, fill_wen_i, fill_wen_d,
        output fill_tag_wen_i, fill_tag_wen_d, fill_base_addr,
        output stall_if, stall_mem
    );

    modport slave (
        output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
        output mem_data_in, mem_data_valid,
        input  mem_en, mem_addr,
        input  fill_data, fill_word_idx, fill_wen_i, fill_wen_d,
        input  fill_tag_wen_i, fill_tag_wen_d, fill_base_addr,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl
// Refills one cache block at a time for the I-cache or the D-cache over the
// shared main-memory read port. D-cache misses win arbitration. Returned words
// are streamed into the owning cache's data array, then its tag is written.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : cache_fill_ctrl_if.master (miss inputs, memory port,
//                fill outputs, pipeline stalls)
//   dbg_state  : current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE)
module cache_fill_ctrl #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic              clk,
    input  logic              rst,
    cache_fill_ctrl_if.master bus,
    output logic [1:0]        dbg_state
);
    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    // Receive counter needs one extra bit to express "all words received".
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0]      WPB_C    = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0]      LAST_C   = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);
    // A block spans 2*WORDS_PER_BLOCK bytes; clearing these bits aligns it.
    localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ~ADDR_WIDTH'(2 * WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    logic [IDX_W-1:0]      issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]      recv_cnt_q, recv_cnt_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;

    logic                  recv_active;
    logic                  beat;
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  fill_wen_i, fill_wen_d;
    logic                  tag_wen_i, tag_wen_d;
    logic [DATA_WIDTH-1:0] fill_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_I;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_q      <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            base_q      <= base_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        base_d      = base_q;
        mem_en      = 1'b0;
        mem_addr    = '0;
        tag_wen_i   = 1'b0;
        tag_wen_d   = 1'b0;

        // Words can come back while requests are still being issued, so the
        // receive path runs in both ISSUE and WAIT. Surplus valids are dropped.
        recv_active = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && (recv_cnt_q < WPB_C);
        beat        = recv_active && bus.mem_data_valid;
        if (beat) begin
            recv_cnt_d = recv_cnt_q + CNT_W'(1);
        end
        fill_wen_i = beat && (owner_q == OWN_I);
        fill_wen_d = beat && (owner_q == OWN_D);

        case (state_q)
            S_IDLE: begin
                issue_cnt_d = '0;
                recv_cnt_d  = '0;
                if (bus.dcache_miss) begin
                    owner_d = OWN_D;
                    base_d  = bus.dcache_miss_addr & BLK_MASK;
                    state_d = S_ISSUE;
                end else if (bus.icache_miss) begin
                    owner_d = OWN_I;
                    base_d  = bus.icache_miss_addr & BLK_MASK;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_en      = 1'b1;
                mem_addr    = base_q + ADDR_WIDTH'({issue_cnt_q, 1'b0});
                issue_cnt_d = issue_cnt_q + IDX_W'(1);
                if (issue_cnt_q == LAST_IDX) begin
                    // Zero-latency memory delivers the last word during ISSUE.
                    state_d = ((beat && (recv_cnt_q == LAST_C)) || (recv_cnt_q == WPB_C))
                              ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (recv_cnt_d == WPB_C) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                tag_wen_i = (owner_q == OWN_I);
                tag_wen_d = (owner_q == OWN_D);
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign fill_data = bus.mem_data_in;

    assign bus.mem_en         = mem_en;
    assign bus.mem_addr       = mem_addr;
    assign bus.fill_data      = fill_data;
    assign bus.fill_word_idx  = recv_cnt_q[IDX_W-1:0];
    assign bus.fill_wen_i     = fill_wen_i;
    assign bus.fill_wen_d     = fill_wen_d;
    assign bus.fill_tag_wen_i = tag_wen_i;
    assign bus.fill_tag_wen_d = tag_wen_d;
    assign bus.fill_base_addr = base_q;
    assign bus.stall_if       = bus.icache_miss | ((state_q != S_IDLE) && (owner_q == OWN_I));
    assign bus.stall_mem      = bus.dcache_miss | ((state_q != S_IDLE) && (owner_q == OWN_D));
    assign dbg_state          = state_q;
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: a latency/bubble memory model plus a miss-driving
// cache model, logging every request, data write and tag write; each test
// derives the expected logs from block arithmetic and the delivered beats.
module tb_cache_fill_ctrl;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int WPB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    cache_fill_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_BLOCK(WPB)) bus ();

    cache_fill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_BLOCK(WPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // memory model
    int      mem_lat    = 0;
    bit      bubble_en  = 1'b0;
    int      pat_idx    = 0;
    int      extra_left = 0;
    bit      bub_pat [0:4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int      resp_due[$];
    logic [DW-1:0] resp_data[$];

    // cache model: drop a miss the cycle after its tag write
    bit drop_i = 1'b0;
    bit drop_d = 1'b0;

    // logs
    logic [DW-1:0] exp_q[$];      // beats delivered by memory, in order
    int            sent_cyc[$];
    logic [AW-1:0] req_addr[$];
    int            req_cyc[$];
    bit            wr_own[$];     // 1 = D-cache
    int            wr_idx[$];
    logic [DW-1:0] wr_data[$];
    int            wr_cyc[$];
    bit            tag_own[$];
    logic [AW-1:0] tag_base[$];
    int            tag_cyc[$];
    int            both_wen = 0;
    bit            st_if_a[int];
    bit            st_mem_a[int];

    task automatic clear_logs();
        exp_q.delete(); sent_cyc.delete();
        req_addr.delete(); req_cyc.delete();
        wr_own.delete(); wr_idx.delete(); wr_data.delete(); wr_cyc.delete();
        tag_own.delete(); tag_base.delete(); tag_cyc.delete();
        both_wen = 0;
        pat_idx  = 0;
    endtask

    // One clock cycle: cache and memory models act at the falling edge, DUT
    // outputs are sampled 1ns later.
    task automatic step();
        bit go;
        @(negedge clk);
        cyc++;
        if (drop_d) begin bus.dcache_miss = 1'b0; drop_d = 1'b0; end
        if (drop_i) begin bus.icache_miss = 1'b0; drop_i = 1'b0; end
        if (bus.mem_en === 1'b1) begin
            req_addr.push_back(bus.mem_addr);
            req_cyc.push_back(cyc);
            resp_due.push_back(cyc + mem_lat);
            resp_data.push_back(DW'($urandom_range(0, 65535)));
        end
        bus.mem_data_valid = 1'b0;
        bus.mem_data_in    = '0;
        if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
            go = bubble_en ? bub_pat[pat_idx % 5] : 1'b1;
            pat_idx++;
            if (go) begin
                bus.mem_data_valid = 1'b1;
                bus.mem_data_in    = resp_data.pop_front();
                void'(resp_due.pop_front());
                exp_q.push_back(bus.mem_data_in);
                sent_cyc.push_back(cyc);
            end
        end else if (extra_left > 0 && resp_due.size() == 0 && exp_q.size() >= WPB) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data_in    = DW'($urandom_range(0, 65535));
            extra_left--;
        end
        #1;
        st_if_a[cyc]  = bus.stall_if;
        st_mem_a[cyc] = bus.stall_mem;
        if (bus.fill_wen_i === 1'b1 && bus.fill_wen_d === 1'b1) both_wen++;
        if (bus.fill_wen_i === 1'b1 || bus.fill_wen_d === 1'b1) begin
            wr_own.push_back(bus.fill_wen_d === 1'b1);
            wr_idx.push_back(int'(bus.fill_word_idx));
            wr_data.push_back(bus.fill_data);
            wr_cyc.push_back(cyc);
        end
        if (bus.fill_tag_wen_i === 1'b1 || bus.fill_tag_wen_d === 1'b1) begin
            tag_own.push_back(bus.fill_tag_wen_d === 1'b1);
            tag_base.push_back(bus.fill_base_addr);
            tag_cyc.push_back(cyc);
            if (bus.fill_tag_wen_d === 1'b1) drop_d = 1'b1;
            if (bus.fill_tag_wen_i === 1'b1) drop_i = 1'b1;
        end
    endtask

    task automatic flush_mem();
        resp_due.delete();
        resp_data.delete();
    endtask

    // Run until n tag writes have been seen, then two more cycles so the
    // misses are dropped and the controller is back in IDLE.
    task automatic run_fills(input int n, input int budget, output bit timed_out);
        int b;
        b = 0;
        timed_out = 1'b0;
        while (tag_cyc.size() < n && b < budget) begin
            step();
            b++;
        end
        if (tag_cyc.size() < n) begin
            timed_out = 1'b1;
            bus.icache_miss = 1'b0;
            bus.dcache_miss = 1'b0;
            rst = 1'b1;
            flush_mem();
            step();
            rst = 1'b0;
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        tests_run++; if (bus.mem_en !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_en got %b want 0", bus.mem_en); end
        tests_run++; if (bus.mem_addr !== '0) begin tests_failed++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
        tests_run++; if ({bus.fill_wen_i, bus.fill_wen_d, bus.fill_tag_wen_i, bus.fill_tag_wen_d} !== 4'b0) begin
            tests_failed++; $display("FAIL reset_wen got %b want 0000", {bus.fill_wen_i, bus.fill_wen_d, bus.fill_tag_wen_i, bus.fill_tag_wen_d}); end
        tests_run++; if (bus.fill_base_addr !== '0) begin tests_failed++; $display("FAIL reset_base got %h want 0", bus.fill_base_addr); end
        tests_run++; if (bus.fill_word_idx !== '0) begin tests_failed++; $display("FAIL reset_idx got %0d want 0", bus.fill_word_idx); end
        tests_run++; if ({bus.stall_if, bus.stall_mem} !== 2'b00) begin tests_failed++; $display("FAIL reset_stall got %b want 00", {bus.stall_if, bus.stall_mem}); end
        tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d want 0", dbg_state); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_dcache_fill();
        int t0, bad_st;
        bit to;
        logic [AW-1:0] ea;
        clear_logs();
        mem_lat = 4; bubble_en = 1'b0;
        t0 = cyc;
        bus.dcache_miss_addr = 16'h1236;
        bus.dcache_miss      = 1'b1;
        run_fills(1, 60, to);
        tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL dfill_timeout got tag count %0d want 1", tag_cyc.size()); end
        tests_run++; if (req_addr.size() !== WPB) begin tests_failed++; $display("FAIL dfill_req_count got %0d want %0d", req_addr.size(), WPB); end
        for (int k = 0; k < req_addr.size() && k < WPB; k++) begin
            ea = 16'h1230 + AW'(2 * k);
            tests_run++; if (req_addr[k] !== ea || req_cyc[k] !== t0 + 1 + k) begin
                tests_failed++; $display("FAIL dfill_req%0d got %h@%0d want %h@%0d", k, req_addr[k], req_cyc[k], ea, t0 + 1 + k); end
        end
        tests_run++; if (wr_own.size() !== WPB) begin tests_failed++; $display("FAIL dfill_wr_count got %0d want %0d", wr_own.size(), WPB); end
        for (int k = 0; k < wr_own.size() && k < WPB && k < exp_q.size(); k++) begin
            tests_run++; if (wr_own[k] !== 1'b1 || wr_idx[k] !== k || wr_data[k] !== exp_q[k] || wr_cyc[k] !== t0 + 5 + k) begin
                tests_failed++; $display("FAIL dfill_wr%0d got own=%0d idx=%0d data=%h cyc=%0d want own=1 idx=%0d data=%h cyc=%0d",
                    k, wr_own[k], wr_idx[k], wr_data[k], wr_cyc[k], k, exp_q[k], t0 + 5 + k); end
        end
        tests_run++; if (tag_cyc.size() !== 1) begin tests_failed++; $display("FAIL dfill_tag_count got %0d want 1", tag_cyc.size()); end
        if (tag_cyc.size() > 0) begin
            tests_run++; if (tag_cyc[0] !== t0 + 13 || tag_base[0] !== 16'h1230 || tag_own[0] !== 1'b1) begin
                tests_failed++; $display("FAIL dfill_tag got cyc=%0d base=%h own=%0d want cyc=%0d base=1230 own=1", tag_cyc[0] - t0, tag_base[0], tag_own[0], 13); end
        end
        bad_st = 0;
        for (int c = t0 + 1; c <= t0 + 13; c++) if (st_mem_a[c] !== 1'b1 || st_if_a[c] !== 1'b0) bad_st++;
        tests_run++; if (bad_st !== 0) begin tests_failed++; $display("FAIL dfill_stall got %0d bad cycles want 0", bad_st); end
    endtask

    task automatic test_dual_miss();
        int t0, d, lat, bad_own, bad_st;
        bit to;
        clear_logs();
        lat = $urandom_range(0, 5);
        mem_lat = lat; bubble_en = 1'b0;
        t0 = cyc;
        d  = t0 + 9 + lat;
        bus.icache_miss_addr = 16'h0040; bus.dcache_miss_addr = 16'h8008;
        bus.icache_miss = 1'b1;          bus.dcache_miss = 1'b1;
        run_fills(2, 120, to);
        tests_run++; if (to !== 1'b0 || tag_cyc.size() !== 2) begin tests_failed++; $display("FAIL dual_tag_count got %0d want 2", tag_cyc.size()); end
        if (tag_cyc.size() >= 2) begin
            tests_run++; if (tag_own[0] !== 1'b1 || tag_base[0] !== 16'h8000 || tag_cyc[0] !== d) begin
                tests_failed++; $display("FAIL dual_tag_d got own=%0d base=%h cyc=%0d want own=1 base=8000 cyc=%0d", tag_own[0], tag_base[0], tag_cyc[0], d); end
            tests_run++; if (tag_own[1] !== 1'b0 || tag_base[1] !== 16'h0040 || tag_cyc[1] !== d + 10 + lat) begin
                tests_failed++; $display("FAIL dual_tag_i got own=%0d base=%h cyc=%0d want own=0 base=0040 cyc=%0d", tag_own[1], tag_base[1], tag_cyc[1], d + 10 + lat); end
        end
        if (req_addr.size() >= 2 * WPB) begin
            tests_run++; if (req_addr[WPB] !== 16'h0040 || req_cyc[WPB] !== d + 2) begin
                tests_failed++; $display("FAIL dual_i_start got %h@%0d want 0040@%0d", req_addr[WPB], req_cyc[WPB], d + 2); end
        end else begin
            tests_run++; tests_failed++; $display("FAIL dual_req_count got %0d want %0d", req_addr.size(), 2 * WPB);
        end
        bad_own = 0;
        for (int k = 0; k < wr_own.size(); k++) if (wr_own[k] !== (k < WPB)) bad_own++;
        tests_run++; if (bad_own !== 0 || wr_own.size() !== 2 * WPB || both_wen !== 0) begin
            tests_failed++; $display("FAIL dual_wr_owner got %0d bad of %0d (both=%0d) want 0 of %0d", bad_own, wr_own.size(), both_wen, 2 * WPB); end
        bad_st = 0;
        for (int c = t0 + 1; c <= d; c++) if (st_if_a[c] !== 1'b1 || st_mem_a[c] !== 1'b1) bad_st++;
        tests_run++; if (bad_st !== 0) begin tests_failed++; $display("FAIL dual_stall got %0d bad cycles want 0", bad_st); end
    endtask

    task automatic test_bubbles();
        bit to;
        int bad;
        logic [AW-1:0] a;
        clear_logs();
        mem_lat = $urandom_range(0, 3); bubble_en = 1'b1;
        a = AW'($urandom_range(0, 65535));
        bus.dcache_miss_addr = a;
        bus.dcache_miss      = 1'b1;
        run_fills(1, 80, to);
        bubble_en = 1'b0;
        tests_run++; if (to !== 1'b0 || wr_own.size() !== WPB || exp_q.size() !== WPB) begin
            tests_failed++; $display("FAIL bubble_count got wr=%0d beats=%0d want %0d", wr_own.size(), exp_q.size(), WPB); end
        bad = 0;
        for (int k = 0; k < wr_own.size() && k < exp_q.size(); k++)
            if (wr_idx[k] !== k || wr_cyc[k] !== sent_cyc[k] || wr_data[k] !== exp_q[k]) bad++;
        tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL bubble_writes got %0d bad want 0", bad); end
        if (tag_cyc.size() == 1 && sent_cyc.size() == WPB) begin
            tests_run++; if (tag_cyc[0] !== sent_cyc[WPB-1] + 1 || tag_base[0] !== (a & 16'hFFF0)) begin
                tests_failed++; $display("FAIL bubble_tag got %h@%0d want %h@%0d", tag_base[0], tag_cyc[0], a & 16'hFFF0, sent_cyc[WPB-1] + 1); end
        end else begin
            tests_run++; tests_failed++; $display("FAIL bubble_tag_count got %0d want 1", tag_cyc.size());
        end
    endtask

    task automatic test_extra_valid();
        bit to;
        clear_logs();
        mem_lat = 1; bubble_en = 1'b0; extra_left = 2;
        bus.icache_miss_addr = AW'($urandom_range(0, 65535));
        bus.icache_miss      = 1'b1;
        run_fills(1, 60, to);
        repeat (3) step();
        extra_left = 0;
        tests_run++; if (wr_own.size() !== WPB) begin tests_failed++; $display("FAIL extra_wr_count got %0d want %0d", wr_own.size(), WPB); end
        tests_run++; if (tag_cyc.size() !== 1 || to !== 1'b0) begin tests_failed++; $display("FAIL extra_tag_count got %0d want 1", tag_cyc.size()); end
        if (tag_own.size() > 0) begin
            tests_run++; if (tag_own[0] !== 1'b0 || tag_base[0] !== (bus.icache_miss_addr & 16'hFFF0)) begin
                tests_failed++; $display("FAIL extra_tag got own=%0d base=%h want own=0 base=%h", tag_own[0], tag_base[0], bus.icache_miss_addr & 16'hFFF0); end
        end
    endtask

    task automatic test_reset_mid_fill();
        int b, t0;
        bit to;
        logic [AW-1:0] a;
        clear_logs();
        mem_lat = 2; bubble_en = 1'b0;
        a = AW'($urandom_range(0, 65535));
        bus.dcache_miss_addr = a;
        bus.dcache_miss      = 1'b1;
        b = 0;
        while (exp_q.size() < 3 && b < 40) begin step(); b++; end
        tests_run++; if (exp_q.size() !== 3) begin tests_failed++; $display("FAIL rstmid_progress got %0d words want 3", exp_q.size()); end
        rst = 1'b1;
        flush_mem();
        step();
        tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL rstmid_state got %0d want 0", dbg_state); end
        tests_run++; if ({bus.mem_en, bus.fill_wen_i, bus.fill_wen_d, bus.fill_tag_wen_i, bus.fill_tag_wen_d} !== 5'b0) begin
            tests_failed++; $display("FAIL rstmid_strobes got %b want 00000", {bus.mem_en, bus.fill_wen_i, bus.fill_wen_d, bus.fill_tag_wen_i, bus.fill_tag_wen_d}); end
        tests_run++; if (bus.mem_addr !== '0 || bus.fill_base_addr !== '0 || bus.fill_word_idx !== '0 || bus.fill_data !== '0) begin
            tests_failed++; $display("FAIL rstmid_outputs got addr=%h base=%h idx=%0d data=%h want 0", bus.mem_addr, bus.fill_base_addr, bus.fill_word_idx, bus.fill_data); end
        tests_run++; if (tag_cyc.size() !== 0) begin tests_failed++; $display("FAIL rstmid_no_tag got %0d tags want 0", tag_cyc.size()); end
        rst = 1'b0;
        clear_logs();
        t0 = cyc;
        run_fills(1, 60, to);
        tests_run++; if (req_addr.size() == 0 || req_addr[0] !== (a & 16'hFFF0) || req_cyc[0] !== t0 + 1) begin
            tests_failed++; $display("FAIL rstmid_restart got %0d reqs want first %h@%0d", req_addr.size(), a & 16'hFFF0, t0 + 1); end
        tests_run++; if (wr_idx.size() !== WPB || wr_idx[0] !== 0) begin
            tests_failed++; $display("FAIL rstmid_words got %0d writes want %0d from idx 0", wr_idx.size(), WPB); end
        tests_run++; if (to !== 1'b0 || tag_cyc.size() !== 1 || tag_cyc[0] !== t0 + 11) begin
            tests_failed++; $display("FAIL rstmid_tag got %0d tags want 1 at %0d", tag_cyc.size(), t0 + 11); end
    endtask

    task automatic test_wrap();
        bit to;
        int bad;
        logic [AW-1:0] ea;
        clear_logs();
        mem_lat = $urandom_range(0, 4); bubble_en = 1'b0;
        bus.icache_miss_addr = 16'hFFFE;
        bus.icache_miss      = 1'b1;
        run_fills(1, 60, to);
        bad = 0;
        for (int k = 0; k < req_addr.size(); k++) begin
            ea = 16'hFFF0 + AW'(2 * k);
            if (req_addr[k] !== ea) bad++;
        end
        tests_run++; if (bad !== 0 || req_addr.size() !== WPB) begin tests_failed++; $display("FAIL wrap_addr got %0d bad of %0d want 0 of %0d", bad, req_addr.size(), WPB); end
        tests_run++; if (to !== 1'b0 || tag_base.size() !== 1 || tag_base[0] !== 16'hFFF0 || tag_own[0] !== 1'b0) begin
            tests_failed++; $display("FAIL wrap_tag got %0d tags want one I tag at fff0", tag_base.size()); end
    endtask

    task automatic test_random_fills();
        bit to;
        int mode, n, t0, bad;
        bit eown[$];
        logic [AW-1:0] ebase[$];
        logic [AW-1:0] ai, ad, ea;
        for (int it = 0; it < 6; it++) begin
            clear_logs();
            eown.delete(); ebase.delete();
            mem_lat = $urandom_range(0, 6);
            bubble_en = ($urandom_range(0, 1) == 1);
            mode = $urandom_range(0, 2);
            ai = AW'($urandom_range(0, 65535));
            ad = AW'($urandom_range(0, 65535));
            bus.icache_miss_addr = ai; bus.dcache_miss_addr = ad;
            // D first, then I, each block-aligned to 16 bytes
            if (mode != 1) begin eown.push_back(1'b1); ebase.push_back(ad & 16'hFFF0); end
            if (mode != 0) begin eown.push_back(1'b0); ebase.push_back(ai & 16'hFFF0); end
            n  = eown.size();
            t0 = cyc;
            bus.dcache_miss = (mode != 1);
            bus.icache_miss = (mode != 0);
            run_fills(n, 200, to);
            bubble_en = 1'b0;
            tests_run++; if (to !== 1'b0 || tag_cyc.size() !== n || wr_own.size() !== n * WPB || exp_q.size() !== n * WPB) begin
                tests_failed++; $display("FAIL rand%0d_counts got tags=%0d wr=%0d want tags=%0d wr=%0d", it, tag_cyc.size(), wr_own.size(), n, n * WPB); end
            else begin
                bad = 0;
                for (int f = 0; f < n; f++) begin
                    if (tag_own[f] !== eown[f] || tag_base[f] !== ebase[f] || tag_cyc[f] !== sent_cyc[f * WPB + WPB - 1] + 1) bad++;
                    for (int k = 0; k < WPB; k++) begin
                        ea = ebase[f] + AW'(2 * k);
                        if (wr_own[f * WPB + k] !== eown[f] || wr_idx[f * WPB + k] !== k || wr_data[f * WPB + k] !== exp_q[f * WPB + k]) bad++;
                        if (req_addr[f * WPB + k] !== ea) bad++;
                    end
                end
                tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL rand%0d_fills got %0d bad items want 0", it, bad); end
                tests_run++; if (req_cyc[0] !== t0 + 1) begin tests_failed++; $display("FAIL rand%0d_start got %0d want %0d", it, req_cyc[0], t0 + 1); end
            end
        end
    endtask

    initial begin
        bus.icache_miss      = 1'b0;
        bus.icache_miss_addr = '0;
        bus.dcache_miss      = 1'b0;
        bus.dcache_miss_addr = '0;
        bus.mem_data_in      = '0;
        bus.mem_data_valid   = 1'b0;
        test_reset();
        test_dcache_fill();
        test_dual_miss();
        test_bubbles();
        test_extra_valid();
        test_reset_mid_fill();
        test_wrap();
        test_random_fills();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
